// File: rtl/fetch_pkg.sv
// Fetch stage shared types: FSM state, IF/ID bundle, skid entry.
// Also holds the default bubble instruction word.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HELD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'hE1A0_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
  } skid_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer for a returned {instr, pc+8} pair.
// Ports: clk, rst_n, load, clear, din -> dout, full. Load beats clear.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  clear,
  input  skid_t din,
  output skid_t dout,
  output logic  full
);

  skid_t data_q, data_d;
  logic  full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load) begin
      data_d = din;
      full_d = 1'b1;
    end else if (clear) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch with memory handshake, skid buffer and IF/ID reg.
// Ports: hazard (StallF/FlushD), redirect (PCSrcW), imem_*, IF/ID out.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        FlushD,
  input  logic        PCSrcW,
  input  logic [31:0] BranchTargetW,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus8D,
  output logic        ValidD
);

  fetch_state_e st_q, st_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_q, req_d;
  if_id_t       ifid_q, ifid_d;

  logic         skid_ld, skid_clr, skid_full;
  skid_t        skid_din, skid_dout;

  logic [31:0]  tgt;
  if_id_t       bub;

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst_n (reset),
    .load  (skid_ld),
    .clear (skid_clr),
    .din   (skid_din),
    .dout  (skid_dout),
    .full  (skid_full)
  );

  always_comb begin
    st_d     = st_q;
    pc_d     = pc_q;
    req_d    = req_q;
    ifid_d   = ifid_q;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    skid_din = '{instr: imem_rdata,
                 pc8:   req_q + 32'd8};
    tgt      = BranchTargetW & ~32'h3;
    bub       = ifid_q;
    bub.instr = NOP_INSTR;
    bub.valid = 1'b0;

    unique case (st_q)
      FETCH: begin
        if (PCSrcW) begin
          pc_d   = tgt;
          ifid_d = bub;
          if (imem_ready) req_d = tgt;
          else            st_d  = DRAIN;
        end else if (imem_ready) begin
          pc_d  = req_q + 32'd4;
          req_d = req_q + 32'd4;
          if (StallF) begin
            skid_ld = 1'b1;
            st_d    = HELD;
          end else begin
            ifid_d = '{instr: imem_rdata,
                       pc8:   req_q + 32'd8,
                       valid: 1'b1};
          end
        end else if (!StallF) begin
          ifid_d = bub;
        end
      end
      HELD: begin
        if (PCSrcW) begin
          pc_d     = tgt;
          req_d    = tgt;
          ifid_d   = bub;
          skid_clr = 1'b1;
          st_d     = FETCH;
        end else if (!StallF) begin
          ifid_d   = '{instr: skid_dout.instr,
                       pc8:   skid_dout.pc8,
                       valid: skid_full};
          req_d    = pc_q;
          skid_clr = 1'b1;
          st_d     = FETCH;
        end
      end
      DRAIN: begin
        // The response still owed belongs to the abandoned address.
        if (PCSrcW) begin
          pc_d   = tgt;
          ifid_d = bub;
        end else if (!StallF) begin
          ifid_d = bub;
        end
        if (imem_ready) begin
          req_d = pc_d;
          st_d  = FETCH;
        end
      end
      default: st_d = FETCH;
    endcase

    if (FlushD) ifid_d = bub;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= FETCH;
      pc_q   <= RESET_PC;
      req_q  <= RESET_PC;
      ifid_q <= '{instr: NOP_INSTR,
                  pc8:   32'h0,
                  valid: 1'b0};
    end else begin
      st_q   <= st_d;
      pc_q   <= pc_d;
      req_q  <= req_d;
      ifid_q <= ifid_d;
    end
  end

  // Gated by reset so the request drops the moment reset asserts.
  assign imem_req  = reset && (st_q != HELD);
  assign imem_addr = req_q;
  assign InstrD    = ifid_q.instr;
  assign PCPlus8D  = ifid_q.pc8;
  assign ValidD    = ifid_q.valid;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, wait states, stall,
// redirects, flush, address wrap and mid-request reset.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StallF = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcW = 1'b0;
  logic [31:0] BranchTargetW = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCPlus8D;
  logic        ValidD;

  int checks = 0;
  int errors = 0;
  logic [97:0] got, exp;

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'h9E37_79B9;
  endfunction

  assign imem_rdata = w(imem_addr);

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .StallF        (StallF),
    .FlushD        (FlushD),
    .PCSrcW        (PCSrcW),
    .BranchTargetW (BranchTargetW),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .InstrD        (InstrD),
    .PCPlus8D      (PCPlus8D),
    .ValidD        (ValidD)
  );

  // Address is only meaningful while a request is up.
  function automatic logic [97:0] obs();
    return {imem_req, imem_req ? imem_addr : 32'h0,
            InstrD, PCPlus8D, ValidD};
  endfunction

  function automatic logic [97:0] mk(
    input logic r, input logic [31:0] a,
    input logic [31:0] i, input logic [31:0] p,
    input logic v);
    return {r, r ? a : 32'h0, i, p, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    got = obs();
    exp = mk(0, 0, NOP, 0, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rst_hold got %h want %h", got, exp);
    end
    reset = 1'b1;
    #1;
    got = obs();
    exp = mk(1, 0, NOP, 0, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rst_first_req got %h want %h", got, exp);
    end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      tick();
      got = obs();
      exp = mk(1, 4 * (i + 1), w(4 * i), 4 * i + 8, 1);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stream%0d got %h want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_wait();
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      got = obs();
      exp = mk(1, 32'h10, NOP, 32'h14, 0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL wait%0d got %h want %h", k, got, exp);
      end
    end
    imem_ready = 1'b1;
    tick();
    got = obs();
    exp = mk(1, 32'h14, w(32'h10), 32'h18, 1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL wait_done got %h want %h", got, exp);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick();
      got = obs();
      exp = mk(1, 32'h18 + 4 * i, w(32'h14 + 4 * i),
               32'h1C + 4 * i, 1);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pre_stall%0d got %h want %h", i, got, exp);
      end
    end
    StallF = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      got = obs();
      exp = mk(0, 0, w(32'h1C), 32'h24, 1);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL held%0d got %h want %h", k, got, exp);
      end
    end
    StallF = 1'b0;
    tick();
    got = obs();
    exp = mk(1, 32'h24, w(32'h20), 32'h28, 1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL unstall got %h want %h", got, exp);
    end
    tick();
    got = obs();
    exp = mk(1, 32'h28, w(32'h24), 32'h2C, 1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL post_stall got %h want %h", got, exp);
    end
  endtask

  task automatic test_drain();
    imem_ready = 1'b0;
    tick();
    got = obs();
    exp = mk(1, 32'h28, NOP, 32'h2C, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL drain_pend got %h want %h", got, exp);
    end
    PCSrcW = 1'b1;
    BranchTargetW = 32'h100;
    for (int k = 0; k < 2; k++) begin
      tick();
      PCSrcW = 1'b0;
      got = obs();
      exp = mk(1, 32'h28, NOP, 32'h2C, 0);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL drain%0d got %h want %h", k, got, exp);
      end
    end
    imem_ready = 1'b1;
    tick();
    got = obs();
    exp = mk(1, 32'h100, NOP, 32'h2C, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL drain_discard got %h want %h", got, exp);
    end
    tick();
    got = obs();
    exp = mk(1, 32'h104, w(32'h100), 32'h108, 1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL drain_target got %h want %h", got, exp);
    end
  endtask

  task automatic test_held_redirect();
    StallF = 1'b1;
    tick();
    got = obs();
    exp = mk(0, 0, w(32'h100), 32'h108, 1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL hr_held got %h want %h", got, exp);
    end
    PCSrcW = 1'b1;
    BranchTargetW = 32'h203;
    tick();
    got = obs();
    exp = mk(1, 32'h200, NOP, 32'h108, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL hr_redirect got %h want %h", got, exp);
    end
    PCSrcW = 1'b0;
    StallF = 1'b0;
    tick();
    got = obs();
    exp = mk(1, 32'h204, w(32'h200), 32'h208, 1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL hr_target got %h want %h", got, exp);
    end
  endtask

  task automatic test_flush();
    FlushD = 1'b1;
    tick();
    got = obs();
    exp = mk(1, 32'h208, NOP, 32'h208, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL flush got %h want %h", got, exp);
    end
    FlushD = 1'b0;
    tick();
    got = obs();
    exp = mk(1, 32'h20C, w(32'h208), 32'h210, 1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL flush_next got %h want %h", got, exp);
    end
    FlushD = 1'b1;
    StallF = 1'b1;
    tick();
    got = obs();
    exp = mk(0, 0, NOP, 32'h210, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL flush_stall got %h want %h", got, exp);
    end
    FlushD = 1'b0;
    StallF = 1'b0;
    tick();
    got = obs();
    exp = mk(1, 32'h210, w(32'h20C), 32'h214, 1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL flush_skid got %h want %h", got, exp);
    end
  endtask

  task automatic test_wrap();
    PCSrcW = 1'b1;
    BranchTargetW = 32'hFFFF_FFFC;
    tick();
    got = obs();
    exp = mk(1, 32'hFFFF_FFFC, NOP, 32'h214, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL wrap_redir got %h want %h", got, exp);
    end
    PCSrcW = 1'b0;
    tick();
    got = obs();
    exp = mk(1, 32'h0, w(32'hFFFF_FFFC), 32'h4, 1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL wrap got %h want %h", got, exp);
    end
    tick();
    got = obs();
    exp = mk(1, 32'h4, w(32'h0), 32'h8, 1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL wrap_next got %h want %h", got, exp);
    end
  endtask

  task automatic test_reset_mid();
    imem_ready = 1'b0;
    tick();
    got = obs();
    exp = mk(1, 32'h4, NOP, 32'h8, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rm_wait got %h want %h", got, exp);
    end
    reset = 1'b0;
    #1;
    got = obs();
    exp = mk(0, 0, NOP, 0, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rm_async got %h want %h", got, exp);
    end
    imem_ready = 1'b1;
    tick();
    got = obs();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rm_inflight got %h want %h", got, exp);
    end
    reset = 1'b1;
    #1;
    got = obs();
    exp = mk(1, 0, NOP, 0, 0);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rm_release got %h want %h", got, exp);
    end
    tick();
    got = obs();
    exp = mk(1, 32'h4, w(32'h0), 32'h8, 1);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL rm_first got %h want %h", got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_drain();
    test_held_redirect();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'hE1A0_0000 (MOV r0,r0), is the instruction word used for bubbles.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 StallF  in  1  hazard unit: hold PC and IF/ID register.
REQ-006 FlushD  in  1  hazard unit: turn the IF/ID contents into a bubble.
REQ-007 PCSrcW  in  1  branch/PC-write redirect taken.
REQ-008 BranchTargetW  in  32  redirect address.
REQ-009 imem_req  out  1  instruction memory request.
REQ-010 imem_addr  out  32  request address, word aligned.
REQ-011 imem_ready  in  1  memory accepts the request and returns data this cycle.
REQ-012 imem_rdata  in  32  instruction word, valid when imem_ready=1.
REQ-013 InstrD  out  32  IF/ID instruction to decode.
REQ-014 PCPlus8D  out  32  fetch address of InstrD + 8.
REQ-015 ValidD  out  1  InstrD is a real instruction.

Function
REQ-016 States: FETCH (request outstanding), DRAIN (discarding a stale request), HELD (returned word parked in the skid buffer).
REQ-017 FETCH and DRAIN: imem_req=1 and imem_addr=ReqAddr; HELD: imem_req=0.
REQ-018 ReqAddr SHALL stay stable from request issue until imem_ready, and is loaded with the PC when a new request starts.
REQ-019 FETCH, imem_ready=1, PCSrcW=0, StallF=0: IF/ID <= {imem_rdata, ReqAddr+8, 1}; PC <= ReqAddr+4; stay in FETCH with a new request next cycle (one instruction per cycle at zero wait states).
REQ-020 FETCH, imem_ready=1, PCSrcW=0, StallF=1: buffer <= {imem_rdata, ReqAddr+8}; PC <= ReqAddr+4; IF/ID holds; go to HELD.
REQ-021 FETCH, imem_ready=0, no redirect: StallF=0 writes a bubble to IF/ID; StallF=1 holds IF/ID.
REQ-022 HELD, StallF=0: IF/ID <= {buffer, 1}; go to FETCH.
REQ-023 HELD, StallF=1: hold everything.
REQ-024 PCSrcW=1 in any state: PC <= BranchTargetW; IF/ID <= bubble; PCSrcW wins over StallF.
REQ-025 On a redirect, FETCH with imem_ready=1 discards the data and issues a target request next cycle.
REQ-026 On a redirect, FETCH with imem_ready=0 goes to DRAIN.
REQ-027 On a redirect, HELD drops the buffer and goes to FETCH.
REQ-028 DRAIN, imem_ready=1: discard the data; go to FETCH at the current PC.
REQ-029 A redirect in DRAIN updates the PC only.
REQ-030 FlushD=1 writes a bubble into IF/ID and wins over StallF; FlushD SHALL NOT affect the PC, the FSM or the buffer.
REQ-031 A bubble is InstrD=NOP_INSTR, ValidD=0, PCPlus8D unchanged.
REQ-032 PC, ReqAddr and PCPlus8 arithmetic SHALL be 32-bit modulo 2^32, so 32'hFFFF_FFFC+4 = 0.
REQ-033 BranchTargetW[1:0] SHALL be ignored (forced to 00).

Reset
REQ-034 While reset=0: PC=RESET_PC, ReqAddr=RESET_PC, state=FETCH, buffer empty, InstrD=NOP_INSTR, PCPlus8D=0, ValidD=0, imem_req=0.
REQ-035 The first request SHALL issue in the first cycle after reset deasserts.
REQ-036 An in-flight memory response across reset SHALL be ignored.

Structure
REQ-037 Package fetch_pkg SHALL hold the state enum (FETCH, DRAIN, HELD) and the NOP_INSTR default.
REQ-038 The single sub-module fetch_skid_buf SHALL be a 1-entry 64-bit buffer with load and clear.

Verification
REQ-039 Zero-wait memory, no stalls, RESET_PC=0 -> ValidD high from the 2nd cycle with PCPlus8D 8, 12, 16, ... and InstrD matching the memory.
REQ-040 imem_ready low for 3 cycles on address 0x10 -> three bubbles (InstrD=E1A00000, ValidD=0), then the 0x10 word with PCPlus8D=0x18.
REQ-041 StallF=1 for 2 cycles while the 0x20 data returns -> state HELD, imem_req=0, IF/ID unchanged, then the 0x20 word delivered once, none lost or duplicated.
REQ-042 PCSrcW=1, BranchTargetW=0x100 while a request is pending (ready low) -> DRAIN, old imem_addr held, response discarded, next request at 0x100, no stale ValidD.
REQ-043 PCSrcW=1 and StallF=1 together in HELD -> buffer dropped, next request at the target.
REQ-044 PC=0xFFFFFFFC fetch -> next request at 0x0.
REQ-045 Reset asserted during WAIT -> all outputs at reset values immediately, then a fetch at RESET_PC.
